// File: rtl/obuf_drain_pkg.sv
// Shared accelerator definitions used by the output-buffer drain engine.
package obuf_drain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } drain_state_e;

  // Cycles between mem_read_req and valid mem_read_data.
  localparam int OBUF_RD_LATENCY = 1;

endpackage

// File: rtl/obuf_drain_if.sv
// Valid/ready word stream from the drain engine toward the DDR write path.
interface obuf_drain_if #(
  parameter int DATA_W = 64
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/obuf_drain_fifo.sv
// Show-ahead skid FIFO; head is visible whenever non-empty, zero when empty.
module obuf_drain_fifo
  import obuf_drain_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int W     = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic          empty_o,
  output logic [CW-1:0] cnt_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign empty_o = (cnt_q == '0);
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/obuf_drain.sv
// Drains a tile from the output buffer read port into a valid/ready stream,
// issuing reads only when the skid FIFO has room for every in-flight word.
module obuf_drain
  import obuf_drain_pkg::*;
#(
  parameter int MEM_DATA_WIDTH = 64,
  parameter int MEM_ADDR_WIDTH = 11,
  parameter int COUNT_W        = 16,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [MEM_ADDR_WIDTH-1:0] base_addr,
  input  logic [COUNT_W-1:0]        num_words,
  output logic                      busy,
  output logic                      done,
  output logic                      mem_read_req,
  output logic [MEM_ADDR_WIDTH-1:0] mem_read_addr,
  input  logic [MEM_DATA_WIDTH-1:0] mem_read_data,
  obuf_drain_if.master              m
);

  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

  drain_state_e              state_q;
  logic                      busy_q, done_q;
  logic [MEM_ADDR_WIDTH-1:0] rd_addr_q;
  logic [COUNT_W-1:0]        rd_left_q, tx_left_q;
  logic [OBUF_RD_LATENCY-1:0] vld_pipe_q;

  logic                      rd_req, hs, fifo_empty;
  logic [FCNT_W-1:0]         fifo_cnt;
  logic [FCNT_W:0]           occ;

  // Credit: FIFO entries plus reads whose data has not landed yet.
  always_comb begin
    occ = (FCNT_W+1)'(fifo_cnt);
    for (int i = 0; i < OBUF_RD_LATENCY; i++) occ = occ + (FCNT_W+1)'(vld_pipe_q[i]);
  end

  assign rd_req = (state_q == ST_READ) && (rd_left_q != '0)
                  && (occ < (FCNT_W+1)'(FIFO_DEPTH));
  assign hs     = m.valid && m.ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_addr_q  <= '0;
      rd_left_q  <= '0;
      tx_left_q  <= '0;
      vld_pipe_q <= '0;
    end else begin
      done_q     <= 1'b0;
      vld_pipe_q <= OBUF_RD_LATENCY'({vld_pipe_q, rd_req});
      if (rd_req) begin
        rd_addr_q <= rd_addr_q + 1'b1;
        rd_left_q <= rd_left_q - 1'b1;
      end
      if (hs) tx_left_q <= tx_left_q - 1'b1;
      case (state_q)
        ST_IDLE: if (start) begin
          rd_addr_q <= base_addr;
          rd_left_q <= num_words;
          tx_left_q <= num_words;
          busy_q    <= 1'b1;
          if (num_words == '0) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_READ;
          end
        end
        ST_READ: if (rd_req && rd_left_q == COUNT_W'(1)) state_q <= ST_FLUSH;
        ST_FLUSH: if (hs && m.last) begin
          state_q <= ST_DONE;
          done_q  <= 1'b1;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  obuf_drain_fifo #(.DEPTH(FIFO_DEPTH), .W(MEM_DATA_WIDTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (vld_pipe_q[OBUF_RD_LATENCY-1]),
    .din_i   (mem_read_data),
    .pop_i   (hs),
    .dout_o  (m.data),
    .empty_o (fifo_empty),
    .cnt_o   (fifo_cnt)
  );

  assign m.valid       = !fifo_empty;
  assign m.last        = m.valid && (tx_left_q == COUNT_W'(1));
  assign mem_read_req  = rd_req;
  assign mem_read_addr = rd_addr_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_obuf_drain.sv
// Directed bench for obuf_drain with a scoreboard of expected reads and words.
module tb_obuf_drain;
  localparam int DW = 64, AW = 11, CW = 16;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] num_words;
  logic          busy, done, mem_read_req;
  logic [AW-1:0] mem_read_addr;
  logic [DW-1:0] mem_read_data = '0;

  obuf_drain_if #(.DATA_W(DW)) m_if ();

  obuf_drain #(.MEM_DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW), .COUNT_W(CW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_words(num_words),
    .busy(busy), .done(done), .mem_read_req(mem_read_req), .mem_read_addr(mem_read_addr),
    .mem_read_data(mem_read_data), .m(m_if)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat_of(logic [AW-1:0] a);
    return {16'hA5C3, 37'd0, a};
  endfunction

  // Buffer model: data equals a tagged address, one cycle after the request.
  always @(posedge clk) if (mem_read_req) mem_read_data <= pat_of(mem_read_addr);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { logic [DW-1:0] data; logic last; } word_t;
  word_t         exp_q[$];
  logic [AW-1:0] addr_q[$];
  int total = 0, bad = 0;
  int t0 = 0, rx_cnt = 0, last_hs = -1, req_gap = 0, done_cyc = -1;
  bit chk_cnt = 0;
  logic          stall_q = 1'b0;
  logic [DW-1:0] stall_data = '0;
  logic          pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: read order, stream words, stall stability, FIFO bound.
  always @(negedge clk) begin
    word_t w;
    if (mem_read_req) begin
      if (addr_q.size() == 0) chk("unexpected_req", 1, 0);
      else chk("rd_addr", mem_read_addr, addr_q.pop_front());
    end else if (busy && addr_q.size() != 0) begin
      req_gap++;
    end
    if (stall_q) begin
      chk("stall_valid", m_if.valid, 1);
      chk("stall_data", m_if.data, stall_data);
    end
    if (m_if.valid && m_if.ready) begin
      if (exp_q.size() == 0) chk("unexpected_word", 1, 0);
      else begin
        w = exp_q.pop_front();
        chk("m_data", m_if.data, w.data);
        chk("m_last", m_if.last, w.last);
        rx_cnt++;
        if (m_if.last) last_hs = cyc - t0;
      end
    end
    if (chk_cnt) chk("fifo_cnt_le4", dut.u_fifo.cnt_o <= 4, 1);
    stall_q    = reset ? 1'b0 : (m_if.valid && !m_if.ready);
    stall_data = m_if.data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [AW-1:0] b, input int n);
    logic [AW-1:0] a;
    base_addr = b;
    num_words = CW'(n);
    start     = 1'b1;
    for (int i = 0; i < n; i++) begin
      a = b + AW'(i);
      addr_q.push_back(a);
      exp_q.push_back('{data: pat_of(a), last: (i == n - 1)});
    end
    rx_cnt = 0; last_hs = -1; req_gap = 0;
    step();
    start = 1'b0;
    t0 = cyc - 1;
  endtask

  task automatic wait_done(input int maxc, input bit toggle);
    int ti = 0;
    done_cyc = -1;
    for (int i = 0; i < maxc; i++) begin
      if (done) begin
        done_cyc = cyc - t0;
        return;
      end
      if (toggle) begin
        m_if.ready = pat[ti % 4];
        ti++;
      end
      step();
    end
    chk("done_timeout", 0, 1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_req"}, mem_read_req, 0);
    chk({tag, "_addr"}, mem_read_addr, 0);
    chk({tag, "_valid"}, m_if.valid, 0);
    chk({tag, "_last"}, m_if.last, 0);
    chk({tag, "_data"}, m_if.data, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; num_words = '0; m_if.ready = 1'b1;
    step(); step();
    chk_idle_outputs("rst");
    reset = 1'b0;
    step();

    // 8-word tile, full throughput
    do_start(11'h010, 8);
    chk("t1_req_c1", mem_read_req, 1);
    chk("t1_addr_c1", mem_read_addr, 11'h010);
    chk("t1_busy", busy, 1);
    step();
    chk("t1_valid_c2", m_if.valid, 0);
    step();
    chk("t1_valid_c3", m_if.valid, 1);
    chk("t1_data_c3", m_if.data, pat_of(11'h010));
    wait_done(40, 0);
    chk("t1_done_cyc", done_cyc, 11);
    chk("t1_last_cyc", last_hs, 10);
    chk("t1_rx", rx_cnt, 8);
    chk("t1_no_gap", req_gap, 0);
    step();
    chk("t1_done_pulse", done, 0);
    chk("t1_busy_end", busy, 0);

    // same tile with backpressure 1,0,0,1
    chk_cnt = 1'b1;
    do_start(11'h010, 8);
    wait_done(100, 1);
    m_if.ready = 1'b1;
    chk_cnt = 1'b0;
    chk("t2_rx", rx_cnt, 8);
    chk("t2_throttled", req_gap > 0, 1);
    chk("t2_exp_empty", exp_q.size(), 0);
    step();

    // address wrap
    do_start(11'h7FE, 4);
    wait_done(40, 0);
    chk("t3_done_cyc", done_cyc, 7);
    chk("t3_rx", rx_cnt, 4);
    chk("t3_addr_empty", addr_q.size(), 0);
    step();

    // zero-length tile
    do_start(11'h123, 0);
    chk("t4_done_c1", done, 1);
    chk("t4_req_c1", mem_read_req, 0);
    chk("t4_valid_c1", m_if.valid, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t4_valid_after", m_if.valid, 0);
      chk("t4_done_after", done, 0);
    end

    // reset mid-tile after 3 words
    do_start(11'h020, 8);
    step(); step(); step(); step();
    reset = 1'b1;
    step();
    chk("t5_rx_before_rst", rx_cnt, 3);
    chk_idle_outputs("t5_rst");
    exp_q.delete();
    addr_q.delete();
    reset = 1'b0;
    step();
    chk("t5_idle_valid", m_if.valid, 0);
    do_start(11'h100, 2);
    wait_done(40, 0);
    chk("t5_done_cyc", done_cyc, 5);
    chk("t5_rx", rx_cnt, 2);
    step();

    // start while busy is ignored
    do_start(11'h040, 6);
    step(); step();
    base_addr = 11'h300; num_words = 16'd2; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(40, 0);
    chk("t6_done_cyc", done_cyc, 9);
    chk("t6_rx", rx_cnt, 6);
    for (int i = 0; i < 4; i++) step();
    chk("t6_exp_empty", exp_q.size(), 0);
    chk("t6_addr_empty", addr_q.size(), 0);
    chk("t6_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
